// File: rtl/next_pc_gen.sv
// Next-PC generator: boot hold, redirect priority, stall-time redirect latching and EPC.
// Optional return-address stack enabled by defining NEXT_PC_RAS_EN.
//
// state   | meaning
// ST_BOOT | holding RESET_VECTOR until the boot counter reaches BOOT_HOLD
// ST_RUN  | normal operation; events redirect, stalls hold cur_pc
// ST_PEND | a redirect was latched while stalled; applied when the stall releases
module next_pc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int          BOOT_HOLD    = 2,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cur_pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jmp_link,
  input  logic        ret,
  input  logic        trap,
  input  logic        eret,
  output logic [31:0] nxt_pc,
  output logic [31:0] epc,
  output logic        redirect,
  output logic        boot_done
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_t;

  localparam logic [3:0] BOOT_HOLD_C = 4'(BOOT_HOLD);

  state_t      state, state_nxt;
  logic [3:0]  boot_cnt;
  logic [31:0] pend_pc;
  logic        pend_trap;
  logic [31:0] epc_q;
  logic [31:0] seq_pc;
  logic [31:0] ev_pc;
  logic [31:0] ev_tgt;
  logic        ev_valid;
  logic        ev_trap;
  logic        latch;
  logic        epc_we;

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  assign seq_pc    = cur_pc + 32'd4;
  assign epc       = epc_q;
  assign boot_done = (state != ST_BOOT);

`ifdef NEXT_PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr, ras_ptr_m1, ras_ptr_p1;
  logic [CW-1:0] ras_cnt;
  logic          ras_empty;
  logic [31:0]   ras_top;
  logic          run_go;
  logic          push;
  logic          pop;

  assign ras_empty  = (ras_cnt == '0);
  assign ras_ptr_m1 = (ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
  assign ras_ptr_p1 = (ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
  assign ras_top    = ras_mem[ras_ptr_m1];
  assign run_go     = (state == ST_RUN) && !stall;
  assign push       = run_go && jmp && jmp_link && !trap && !eret;
  assign pop        = run_go && ret && !trap && !eret && !ras_empty;

  // Circular stack: a push when full silently replaces the oldest entry.
  always_ff @(posedge clk) begin
    if (push) ras_mem[pop ? ras_ptr_m1 : ras_ptr] <= seq_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push && !pop) begin
      ras_ptr <= ras_ptr_p1;
      if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
    end else if (pop && !push) begin
      ras_ptr <= ras_ptr_m1;
      ras_cnt <= ras_cnt - 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{ret, jmp_link, RAS_DEPTH[0]};
`endif

  always_comb begin
    ev_valid = 1'b0;
    ev_trap  = 1'b0;
    ev_pc    = seq_pc;
    if (trap) begin
      ev_valid = 1'b1;
      ev_trap  = 1'b1;
      ev_pc    = TRAP_VECTOR;
    end else if (eret) begin
      ev_valid = 1'b1;
      ev_pc    = epc_q;
    end else if (jmp) begin
      ev_valid = 1'b1;
      ev_pc    = jmp_target;
`ifdef NEXT_PC_RAS_EN
    end else if (ret && !ras_empty) begin
      ev_valid = 1'b1;
      ev_pc    = ras_top;
`endif
    end else if (br_taken) begin
      ev_valid = 1'b1;
      ev_pc    = br_target;
    end
  end

  assign ev_tgt = align(ev_pc);

  // A pending trap may only be replaced by another trap.
  assign latch  = stall && ev_valid &&
                  ((state == ST_RUN) || ((state == ST_PEND) && (ev_trap || !pend_trap)));
  assign epc_we = trap && ((state == ST_RUN) || ((state == ST_PEND) && stall));

  always_comb begin
    state_nxt = state;
    nxt_pc    = seq_pc;
    redirect  = 1'b0;
    case (state)
      ST_BOOT: begin
        nxt_pc = RESET_VECTOR;
        if (boot_cnt + 4'd1 == BOOT_HOLD_C) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          nxt_pc = cur_pc;
          if (ev_valid) state_nxt = ST_PEND;
        end else if (ev_valid) begin
          nxt_pc   = ev_tgt;
          redirect = 1'b1;
        end
      end
      ST_PEND: begin
        if (stall) begin
          nxt_pc = cur_pc;
        end else begin
          nxt_pc    = pend_pc;
          redirect  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        nxt_pc    = RESET_VECTOR;
        state_nxt = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_BOOT;
      boot_cnt  <= 4'd0;
      pend_pc   <= 32'd0;
      pend_trap <= 1'b0;
      epc_q     <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_BOOT) boot_cnt <= boot_cnt + 4'd1;
      if (latch) begin
        pend_pc   <= ev_tgt;
        pend_trap <= ev_trap;
      end else if ((state == ST_PEND) && !stall) begin
        pend_trap <= 1'b0;
      end
      if (epc_we) epc_q <= cur_pc;
    end
  end

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed bench for next_pc_gen: boot, priority, stall latching, EPC, reset, RAS (if enabled).
module tb_next_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cur_pc;
  logic        stall, br_taken, jmp, jmp_link, ret, trap, eret;
  logic [31:0] br_target, jmp_target;
  logic [31:0] nxt_pc, epc;
  logic        redirect, boot_done;

  int n_chk  = 0;
  int n_fail = 0;

  next_pc_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cur_pc     (cur_pc),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .jmp_link   (jmp_link),
    .ret        (ret),
    .trap       (trap),
    .eret       (eret),
    .nxt_pc     (nxt_pc),
    .epc        (epc),
    .redirect   (redirect),
    .boot_done  (boot_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    stall = 0; br_taken = 0; jmp = 0; jmp_link = 0; ret = 0; trap = 0; eret = 0;
    br_target = 32'h0; jmp_target = 32'h0;
  endtask

  initial begin
    rst_n = 0; cur_pc = 32'h0; clear();
    #2;
    chk("rst_nxt_pc", nxt_pc, 32'h0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_boot_done", boot_done, 1'b0);
    chk("rst_epc", epc, 32'h0);
    tick(); tick();

    // boot hold, events ignored
    rst_n = 1; jmp = 1; jmp_target = 32'h100; #1;
    chk("boot0_nxt", nxt_pc, 32'h0);
    chk("boot0_redir", redirect, 1'b0);
    chk("boot0_done", boot_done, 1'b0);
    tick(); jmp = 0; #1;
    chk("boot1_nxt", nxt_pc, 32'h0);
    chk("boot1_done", boot_done, 1'b0);
    tick(); #1;
    chk("boot2_done", boot_done, 1'b1);
    chk("boot2_nxt", nxt_pc, 32'h4);

    cur_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_nxt", nxt_pc, 32'h0);
    chk("wrap_redir", redirect, 1'b0);
    tick();

    cur_pc = 32'h40; trap = 1; jmp = 1; jmp_target = 32'h100; #1;
    chk("prio_trap_nxt", nxt_pc, 32'h80);
    chk("prio_trap_redir", redirect, 1'b1);
    tick();
    chk("prio_epc", epc, 32'h40);
    clear(); cur_pc = 32'h80; eret = 1; #1;
    chk("eret_nxt", nxt_pc, 32'h40);
    chk("eret_redir", redirect, 1'b1);
    tick(); clear();

    cur_pc = 32'h40; jmp = 1; jmp_target = 32'h123; br_taken = 1; br_target = 32'h55; #1;
    chk("jmp_over_br", nxt_pc, 32'h120);
    tick(); clear();
    br_taken = 1; br_target = 32'h55; #1;
    chk("br_nxt", nxt_pc, 32'h54);
    chk("br_redir", redirect, 1'b1);
    tick(); clear();

    // stalled branch applied on release, release-cycle jump ignored
    cur_pc = 32'h500; stall = 1; br_taken = 1; br_target = 32'h203; #1;
    chk("stall0_nxt", nxt_pc, 32'h500);
    chk("stall0_redir", redirect, 1'b0);
    tick(); br_taken = 0; #1;
    chk("stall1_nxt", nxt_pc, 32'h500);
    chk("stall1_redir", redirect, 1'b0);
    tick(); #1;
    chk("stall2_nxt", nxt_pc, 32'h500);
    tick(); stall = 0; jmp = 1; jmp_target = 32'h700; #1;
    chk("release_nxt", nxt_pc, 32'h200);
    chk("release_redir", redirect, 1'b1);
    tick(); jmp = 0; #1;
    chk("post_release_nxt", nxt_pc, 32'h504);
    chk("post_release_redir", redirect, 1'b0);
    tick(); clear();

    // pending trap is not replaced by a later jump
    cur_pc = 32'h600; stall = 1; trap = 1; #1;
    chk("ptrap_stall_nxt", nxt_pc, 32'h600);
    tick();
    chk("ptrap_epc", epc, 32'h600);
    trap = 0; jmp = 1; jmp_target = 32'h300;
    tick(); clear(); #1;
    chk("ptrap_release_nxt", nxt_pc, 32'h80);
    chk("ptrap_release_redir", redirect, 1'b1);
    tick();

    // latest non-trap event wins
    cur_pc = 32'h700; stall = 1; br_taken = 1; br_target = 32'h210;
    tick(); br_taken = 0; jmp = 1; jmp_target = 32'h310;
    tick(); clear(); #1;
    chk("latest_wins_nxt", nxt_pc, 32'h310);
    tick();

    cur_pc = 32'h900; trap = 1; eret = 1; #1;
    chk("trap_eret_nxt", nxt_pc, 32'h80);
    tick(); clear();
    chk("trap_eret_epc", epc, 32'h900);
    cur_pc = 32'h80; eret = 1; #1;
    chk("eret2_nxt", nxt_pc, 32'h900);
    tick(); clear();

    // reset discards a pending redirect
    cur_pc = 32'hA00; stall = 1; jmp = 1; jmp_target = 32'hB00;
    tick(); clear(); rst_n = 0; #1;
    chk("midrst_nxt", nxt_pc, 32'h0);
    chk("midrst_boot_done", boot_done, 1'b0);
    chk("midrst_epc", epc, 32'h0);
    tick(); rst_n = 1; #1;
    chk("reboot_nxt", nxt_pc, 32'h0);
    tick(); tick();
    chk("reboot_seq_nxt", nxt_pc, 32'hA04);
    chk("reboot_redir", redirect, 1'b0);
    chk("reboot_done", boot_done, 1'b1);

`ifdef NEXT_PC_RAS_EN
    cur_pc = 32'h10; jmp = 1; jmp_link = 1; jmp_target = 32'h400; #1;
    chk("call_nxt", nxt_pc, 32'h400);
    tick(); clear();
    cur_pc = 32'h400; ret = 1; #1;
    chk("ret_nxt", nxt_pc, 32'h14);
    chk("ret_redir", redirect, 1'b1);
    tick(); clear();
    for (int i = 1; i <= 5; i++) begin
      cur_pc = 32'(i) << 12; jmp = 1; jmp_link = 1; jmp_target = 32'h8000;
      tick(); clear();
    end
    for (int i = 0; i < 4; i++) begin
      cur_pc = 32'h8000; ret = 1; #1;
      chk($sformatf("pop%0d_nxt", i), nxt_pc, (32'(5 - i) << 12) + 32'h4);
      tick(); clear();
    end
    cur_pc = 32'h40; ret = 1; #1;
    chk("pop_empty_nxt", nxt_pc, 32'h44);
    chk("pop_empty_redir", redirect, 1'b0);
    tick(); clear();
`else
    cur_pc = 32'h20; ret = 1; jmp_link = 1; #1;
    chk("ret_ignored_nxt", nxt_pc, 32'h24);
    chk("ret_ignored_redir", redirect, 1'b0);
    tick(); clear();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
